i2c_master_wr: RTL
==================

I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the clk_i frequency in Hz.
REQ-002 The block SHALL have parameter SCL_HZ, default 100_000, meaning the target SCL frequency in Hz.
REQ-003 The block SHALL have parameter SLAVE_ADDR, default 7'h21, meaning the 7-bit target address; the R/W bit is always 0.
REQ-004 The block SHALL have parameter DATA_BYTES, default 2, range 1..4, meaning the payload bytes per transaction.
REQ-005 clk_i  input  1  system clock; the block uses one clock only.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 write_data_i  input  8*DATA_BYTES  payload; the most significant byte is sent first.
REQ-008 valid_i  input  1  payload valid.
REQ-009 ready_o  output  1  block idle and able to accept a payload.
REQ-010 done_o  output  1  one-cycle pulse when a transaction ends.
REQ-011 error_o  output  1  the last transaction received a NACK; the flag is sticky.
REQ-012 scl_o  output  1  I2C clock; the block drives it push-pull.
REQ-013 sda_oe_o  output  1  SDA pull-down: 1 pulls SDA low, 0 releases it (released reads as 1).
REQ-014 sda_i  input  1  sampled SDA line, already synchronised externally.

Function
REQ-015 The block SHALL generate a quarter-period tick every DIV = CLK_HZ/(4*SCL_HZ) clk_i cycles, using integer division.
- The divider counter SHALL run only while the block is not in IDLE.
- The counter SHALL restart at 0 when a transaction is accepted.
REQ-016 The FSM SHALL have the states IDLE, START, BIT, ACK, STOP and DONE.
REQ-017 In IDLE:
- scl_o=1, sda_oe_o=0, ready_o=1.
- A cycle with valid_i=1 and ready_o=1 SHALL capture {SLAVE_ADDR,1'b0,write_data_i} into a shift register.
- In that cycle the FSM SHALL move to START, and ready_o SHALL be 0 from the next cycle.
- valid_i while ready_o=0 SHALL be ignored; no payload is queued.
REQ-018 START SHALL last 4 ticks: sda_oe_o=1 from tick 1 with scl_o=1, then scl_o=0 from tick 3.
REQ-019 Each BIT and ACK slot SHALL last 4 ticks:
- SDA SHALL change only while scl_o=0 (ticks 0-1).
- scl_o SHALL be 1 during ticks 2-3.
REQ-020 In BIT, sda_oe_o SHALL equal the inverse of the shift register MSB, and the register SHALL shift left at the end of the slot.
REQ-021 After every 8 bits the FSM SHALL enter ACK:
- sda_oe_o=0 for the whole slot.
- sda_i SHALL be sampled at the tick-2 to tick-3 boundary.
REQ-022 The block SHALL send exactly 1 address byte plus DATA_BYTES bytes, i.e. 9*(DATA_BYTES+1) bit slots.
REQ-023 STOP SHALL last 4 ticks:
- sda_oe_o=1 and scl_o=0, then scl_o=1 from tick 1.
- sda_oe_o=0 from tick 3.
REQ-024 DONE SHALL last 1 cycle: done_o=1, then the FSM returns to IDLE with ready_o=1 on the following cycle.
REQ-025 error_o SHALL be cleared when a transaction is accepted.
- It SHALL be set together with done_o when a NACK has occurred.
- It SHALL hold until the next accepted transaction.
REQ-026 done_o SHALL never be asserted while ready_o=1 is being sampled for a new transaction.
REQ-027 Back-to-back transactions: valid_i held high SHALL be accepted in the first IDLE cycle after DONE, giving exactly 1 idle cycle between STOP and the next START.

Reset
REQ-028 Asserting reset_i at any time, including mid-bit, SHALL immediately force:
- FSM to IDLE and all counters to 0.
- scl_o=1, sda_oe_o=0, ready_o=1, done_o=0, error_o=0.
REQ-029 A transaction interrupted by reset SHALL NOT generate done_o or a STOP condition.

Configuration
REQ-030 With I2C_ACK_CHECK_EN defined, a NACK (sda_i=1 in ACK) SHALL abort the transaction:
- The FSM goes directly to STOP, skipping the remaining bytes.
- done_o and error_o SHALL then assert in DONE.
REQ-031 Without I2C_ACK_CHECK_EN, ACK slots are don't-care (SCCB-compatible):
- sda_i SHALL be ignored.
- All bytes SHALL always be sent.
- error_o SHALL stay 0.

Verification (CLK_HZ=100M, SCL_HZ=100k, DIV=250, DATA_BYTES=2, SLAVE_ADDR=7'h21)
REQ-032 Reset held 5 cycles then released -> scl_o=1, sda_oe_o=0, ready_o=1, done_o=0, error_o=0.
REQ-033 write_data_i=16'h12_80 with valid_i pulsed 1 cycle, slave ACKs every byte:
- Bytes 8'h42, 8'h12, 8'h80 observed on SDA, MSB first, SDA stable while scl_o=1.
- done_o pulses exactly once, 1000*(1+27+1)+1 cycles after acceptance.
- error_o=0.
REQ-034 With I2C_ACK_CHECK_EN defined, sda_i=1 in the first ACK:
- STOP follows immediately; no data bytes are sent.
- done_o=1 and error_o=1 in the same cycle.
- The next accepted transaction clears error_o.
REQ-035 Without I2C_ACK_CHECK_EN, sda_i stuck at 1:
- All 27 slots are sent.
- done_o pulses; error_o=0.
REQ-036 valid_i held high for 3 transactions (16'h1280, 16'h1101, 16'h0C04):
- Exactly 3 done_o pulses.
- 1 idle cycle between each DONE and the next START.
- Inputs changing while ready_o=0 do not affect the bits in flight.
REQ-037 reset_i asserted in the middle of the second data byte:
- Outputs go to idle values within the same cycle.
- No done_o pulse.
- A new payload accepted after release transmits correctly.

Source files
------------

// File: rtl/i2c_master_wr.sv
// rtl/i2c_master_wr.sv - write-only I2C master: START, address+W, DATA_BYTES payload bytes, STOP
//
// Sends {SLAVE_ADDR, 1'b0, write_data_i} MSB first. Every bus slot is four
// quarter-period ticks long, with one tick every CLK_HZ/(4*SCL_HZ) clk_i cycles.
//
// Optional feature macro: I2C_ACK_CHECK_EN
//   defined   : a NACK aborts the transfer, goes straight to STOP and raises error_o.
//   undefined : ACK slots are ignored (SCCB style), all bytes are sent, error_o stays 0.
//
// Ports:
//   clk_i        in   system clock
//   reset_i      in   asynchronous active-high reset
//   write_data_i in   payload [8*DATA_BYTES-1:0], most significant byte sent first
//   valid_i      in   payload valid, taken when ready_o=1
//   ready_o      out  idle, a payload can be accepted
//   done_o       out  one-cycle pulse at the end of a transaction
//   error_o      out  sticky NACK flag of the last transaction
//   scl_o        out  I2C clock, push-pull
//   sda_oe_o     out  1 pulls SDA low, 0 releases it
//   sda_i        in   synchronised SDA line
module i2c_master_wr #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         SCL_HZ     = 100_000,
  parameter logic [6:0] SLAVE_ADDR = 7'h21,
  parameter int         DATA_BYTES = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [8*DATA_BYTES-1:0] write_data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    scl_o,
  output logic                    sda_oe_o,
  input  logic                    sda_i
);

  localparam int DIV_RAW = CLK_HZ / (4 * SCL_HZ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = 8 * (DATA_BYTES + 1);

`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      qtr;       // quarter index inside the current slot
  logic [2:0]      bit_cnt;   // bit index inside the current byte
  logic [2:0]      byte_cnt;  // 0 = address byte, then payload bytes
  logic [SW-1:0]   sr;
  logic            nack;      // a NACK was sampled during this transaction
  logic            tick;

  assign tick = (div_cnt == DW'(DIV - 1));

  // Outputs for quarter k are written on the tick that ends quarter k-1,
  // so every bus output comes straight from a flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      div_cnt  <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sr       <= '0;
      nack     <= 1'b0;
      scl_o    <= 1'b1;
      sda_oe_o <= 1'b0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      if (state == IDLE || tick)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);

      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            sr       <= {SLAVE_ADDR, 1'b0, write_data_i};
            state    <= START;
            ready_o  <= 1'b0;
            error_o  <= 1'b0;
            nack     <= 1'b0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end

        START: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: sda_oe_o <= 1'b1;            // SDA falls while SCL high
              2'd2: scl_o    <= 1'b0;
              2'd3: begin
                state    <= BIT;
                sda_oe_o <= ~sr[SW-1];
              end
              default: ;
            endcase
          end
        end

        BIT: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                scl_o   <= 1'b0;
                sr      <= {sr[SW-2:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state    <= ACK;
                  sda_oe_o <= 1'b0;
                end else begin
                  sda_oe_o <= ~sr[SW-2];         // next bit after the shift
                end
              end
              default: ;
            endcase
          end
        end

        ACK: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: scl_o <= 1'b1;
              2'd2: nack  <= nack | sda_i;       // middle of the SCL-high phase
              2'd3: begin
                scl_o <= 1'b0;
                if (byte_cnt == 3'(DATA_BYTES) || (ACK_CHECK && nack)) begin
                  state    <= STOP;
                  sda_oe_o <= 1'b1;
                end else begin
                  state    <= BIT;
                  byte_cnt <= byte_cnt + 3'd1;
                  sda_oe_o <= ~sr[SW-1];
                end
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: scl_o    <= 1'b1;
              2'd2: sda_oe_o <= 1'b0;            // SDA rises while SCL high
              2'd3: begin
                state   <= DONE;
                done_o  <= 1'b1;
                error_o <= ACK_CHECK && nack;
              end
              default: ;
            endcase
          end
        end

        DONE: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
